jacobi_pair_scheduler: RTL and testbench
========================================

# jacobi_pair_scheduler

Sequences the off-diagonal (p,q) index pairs of a cyclic-by-row Jacobi eigenvalue sweep, one pair at a time. It sits beside the Jacobi main controller. Each pair is offered over a valid/ready handshake to the controller, which drives the vectoring CORDIC, the BRAM and the rotation CORDIC. The scheduler then holds until the controller reports that the pair's rotation has been written back. It counts sweeps and signals completion of the whole decomposition.

## Interface
Parameters:
- N, default JACOBI_N (4): matrix dimension; N >= 2.
- NUM_SWEEPS, default JACOBI_SWEEPS (6): number of full sweeps; >= 1.
- IDX_W, default JACOBI_IDX_WIDTH ($clog2(N)): index width.
- SWP_W, default JACOBI_SWEEP_WIDTH ($clog2(NUM_SWEEPS+1)): sweep counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  start a full schedule; honoured only in IDLE.
- pair_p_o  out  IDX_W  row index p of offered pair.
- pair_q_o  out  IDX_W  column index q of offered pair (q > p).
- pair_last_o  out  1  offered pair is the last of its sweep.
- pair_vld_o  out  1  pair offered.
- pair_rdy_i  in  1  controller accepts pair.
- cmpl_i  in  1  one-cycle pulse: accepted pair fully processed.
- sweep_o  out  SWP_W  index of the current sweep, 0-based.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse, all sweeps finished.
- err_o  out  1  sticky protocol error: cmpl_i seen outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start_i=1 loads p=0, q=1, sweep=0 and clears err_o.
  - Next state ISSUE.
- ISSUE:
  - pair_vld_o=1 with p/q held stable.
  - On pair_vld_o & pair_rdy_i, go to WAIT.
- WAIT:
  - pair_vld_o=0.
  - On cmpl_i, advance the pair: if q < N-1 then q++; else if p < N-2 then p++, q=p+2 (new p plus 1).
  - Otherwise the sweep ends: p=0, q=1, sweep++.
  - If the completed pair was the last pair of sweep NUM_SWEEPS-1, go to DONE (sweep_o holds NUM_SWEEPS-1). Otherwise go to ISSUE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Pair order: (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1). That is M = N(N-1)/2 pairs per sweep, NUM_SWEEPS·M in total.
- pair_last_o = (p==N-2 && q==N-1); it is combinational from the registered p/q.
- Boundary conditions:
  - start_i outside IDLE is ignored.
  - cmpl_i in IDLE, ISSUE or DONE sets err_o and otherwise does nothing.
  - pair_rdy_i without pair_vld_o is ignored.
  - err_o stays set until rst or an accepted start_i.
  - rst in any state returns to IDLE immediately. An in-flight pair is abandoned; the controller must also be reset.

## Timing
- Reset values: pair_p_o=0, pair_q_o=1, pair_last_o=(N==2), pair_vld_o=0, sweep_o=0, busy_o=0, done_o=0, err_o=0.
- Outputs are registered except pair_last_o and busy_o, which decode registers only.
- start_i at edge t: pair_vld_o=1 and busy_o=1 from cycle t+1.
- Handshake at edge t: pair_vld_o=0 from cycle t+1. Earliest cmpl_i is at cycle t+1.
- cmpl_i at edge t:
  - the next pair is offered from t+1;
  - on the final pair, done_o=1 in cycle t+1, busy_o=1 in that cycle and 0 from t+2.
- A new start_i is accepted from cycle t+2 after the final cmpl_i.
- pair_vld_o never drops without a handshake. p/q never change while pair_vld_o=1.

## Structure
- The common package adds JACOBI_N, JACOBI_SWEEPS, JACOBI_IDX_WIDTH, JACOBI_SWEEP_WIDTH, and typedef enum logic [1:0] jacobi_sched_state_t {IDLE, ISSUE, WAIT, DONE}.
- Single module; no sub-modules. The pair-advance logic is an internal function.
- Elaboration-time assertions check N >= 2 and NUM_SWEEPS >= 1.

## Test plan
- N=4, NUM_SWEEPS=2, pair_rdy_i=1, cmpl_i 3 cycles after each handshake:
  - 12 pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) twice;
  - pair_last_o only on (2,3);
  - sweep_o steps 0→1;
  - a single done_o, then busy_o=0.
- Backpressure: pair_rdy_i low 5 cycles on pair (1,2) → pair_vld_o, p and q stable throughout; exactly one transfer.
- Protocol errors:
  - cmpl_i in IDLE → err_o=1, state unchanged;
  - start_i → err_o=0;
  - cmpl_i during ISSUE → err_o=1, pair still offered.
- start_i pulsed during WAIT and on the DONE cycle → ignored; pair sequence unaffected.
- rst asserted mid-WAIT on pair (0,3) → same cycle: pair_vld_o=0, busy_o=0, p/q=0/1, sweep_o=0. A following start_i restarts at (0,1).
- N=2, NUM_SWEEPS=1 → single pair (0,1) with pair_last_o=1; done_o the cycle after its cmpl_i.

Source files
------------

// File: rtl/jacobi_pair_scheduler_pkg.sv
// Shared definitions for the Jacobi eigenvalue engine: default matrix size,
// sweep count, derived index widths and the pair scheduler state encoding.
package jacobi_pair_scheduler_pkg;

    localparam int JACOBI_N           = 4;
    localparam int JACOBI_SWEEPS      = 6;
    localparam int JACOBI_IDX_WIDTH   = $clog2(JACOBI_N);
    localparam int JACOBI_SWEEP_WIDTH = $clog2(JACOBI_SWEEPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } jacobi_sched_state_t;

endpackage

// File: rtl/jacobi_pair_scheduler.sv
// Cyclic-by-row Jacobi pair scheduler. Offers the off-diagonal (p,q) pairs
// of each sweep to the main controller one at a time, waits for each pair's
// rotation write-back, counts sweeps and pulses done_o at the end.
//
// Handshake: a pair transfers on a rising edge where pair_vld_o and
// pair_rdy_i are both high. Once raised, pair_vld_o stays high and
// pair_p_o/pair_q_o/pair_last_o stay stable until that transfer; pair_rdy_i
// is ignored while pair_vld_o is low.
module jacobi_pair_scheduler
    import jacobi_pair_scheduler_pkg::*;
#(
    parameter int N          = JACOBI_N,
    parameter int NUM_SWEEPS = JACOBI_SWEEPS,
    parameter int IDX_W      = JACOBI_IDX_WIDTH,
    parameter int SWP_W      = JACOBI_SWEEP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic [IDX_W-1:0]    pair_p_o,
    output logic [IDX_W-1:0]    pair_q_o,
    output logic                pair_last_o,
    output logic                pair_vld_o,
    input  logic                pair_rdy_i,
    input  logic                cmpl_i,
    output logic [SWP_W-1:0]    sweep_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output jacobi_sched_state_t state_o
);

    // Last row index that still has pairs, and last column index.
    localparam logic [IDX_W-1:0] P_MAX     = IDX_W'(N - 2);
    localparam logic [IDX_W-1:0] Q_MAX     = IDX_W'(N - 1);
    localparam logic [SWP_W-1:0] SWP_FINAL = SWP_W'(NUM_SWEEPS - 1);

    if (N < 2) begin : g_bad_n
        $error("jacobi_pair_scheduler: N must be at least 2");
    end
    if (NUM_SWEEPS < 1) begin : g_bad_sweeps
        $error("jacobi_pair_scheduler: NUM_SWEEPS must be at least 1");
    end

    jacobi_sched_state_t state;
    logic [IDX_W-1:0]    p_r;
    logic [IDX_W-1:0]    q_r;
    logic [SWP_W-1:0]    sweep_r;
    logic                vld_r;
    logic                done_r;
    logic                err_r;

    // Next pair in row order; wrap flags the end of a sweep, where the
    // returned pair is the first pair (0,1) of the following sweep.
    function automatic logic [2*IDX_W:0] advance(input logic [IDX_W-1:0] p,
                                                 input logic [IDX_W-1:0] q);
        logic [IDX_W-1:0] np;
        logic [IDX_W-1:0] nq;
        logic             wrap;
        np   = p;
        nq   = q;
        wrap = 1'b0;
        if (q < Q_MAX) begin
            nq = q + IDX_W'(1);
        end else if (p < P_MAX) begin
            np = p + IDX_W'(1);
            nq = p + IDX_W'(2);
        end else begin
            np   = '0;
            nq   = IDX_W'(1);
            wrap = 1'b1;
        end
        return {wrap, np, nq};
    endfunction

    logic [2*IDX_W:0] adv;
    logic             adv_wrap;
    logic [IDX_W-1:0] adv_p;
    logic [IDX_W-1:0] adv_q;
    logic             last_pair;

    assign adv       = advance(p_r, q_r);
    assign adv_wrap  = adv[2*IDX_W];
    assign adv_p     = adv[2*IDX_W-1:IDX_W];
    assign adv_q     = adv[IDX_W-1:0];
    assign last_pair = (p_r == P_MAX) && (q_r == Q_MAX);

    // Scheduler FSM: state, pair indices, sweep counter and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            p_r     <= '0;
            q_r     <= IDX_W'(1);
            sweep_r <= '0;
            vld_r   <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        p_r     <= '0;
                        q_r     <= IDX_W'(1);
                        sweep_r <= '0;
                        err_r   <= 1'b0;
                        vld_r   <= 1'b1;
                        state   <= ISSUE;
                    end
                    // A stray completion flags an error even alongside start.
                    if (cmpl_i) begin
                        err_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cmpl_i) begin
                        err_r <= 1'b1;
                    end
                    if (pair_rdy_i) begin
                        vld_r <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cmpl_i) begin
                        if (last_pair && (sweep_r == SWP_FINAL)) begin
                            // Sweep counter holds on the final sweep index.
                            p_r    <= '0;
                            q_r    <= IDX_W'(1);
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            p_r   <= adv_p;
                            q_r   <= adv_q;
                            if (adv_wrap) begin
                                sweep_r <= sweep_r + SWP_W'(1);
                            end
                            vld_r <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (cmpl_i) begin
                        err_r <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pair_p_o    = p_r;
    assign pair_q_o    = q_r;
    assign pair_last_o = last_pair;
    assign pair_vld_o  = vld_r;
    assign sweep_o     = sweep_r;
    assign busy_o      = (state != IDLE);
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign state_o     = state;

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// Bench for jacobi_pair_scheduler: a protocol vector table, a deterministic
// and a randomized full schedule against a pair-list model, reset mid-pair,
// and an N=2 single-sweep instance.
module tb_jacobi_pair_scheduler;
    import jacobi_pair_scheduler_pkg::*;

    localparam int NA  = 4;
    localparam int SA  = 2;
    localparam int MA  = NA * (NA - 1) / 2;
    localparam int SBW = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT A: N=4, two sweeps ----------------
    logic                start_a = 1'b0, rdy_a = 1'b0, cmpl_a = 1'b0;
    logic [1:0]          p_a, q_a, sweep_a;
    logic                last_a, vld_a, busy_a, done_a, err_a;
    jacobi_sched_state_t state_a;

    jacobi_pair_scheduler #(.N(NA), .NUM_SWEEPS(SA), .IDX_W(2), .SWP_W(2)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a),
        .pair_p_o(p_a), .pair_q_o(q_a), .pair_last_o(last_a),
        .pair_vld_o(vld_a), .pair_rdy_i(rdy_a), .cmpl_i(cmpl_a),
        .sweep_o(sweep_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
        .state_o(state_a)
    );

    // ---------------- DUT B: N=2, one sweep ----------------
    logic                start_b = 1'b0, rdy_b = 1'b0, cmpl_b = 1'b0;
    logic [0:0]          p_b, q_b, sweep_b;
    logic                last_b, vld_b, busy_b, done_b, err_b;
    jacobi_sched_state_t state_b;

    jacobi_pair_scheduler #(.N(2), .NUM_SWEEPS(1), .IDX_W(1), .SWP_W(1)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b),
        .pair_p_o(p_b), .pair_q_o(q_b), .pair_last_o(last_b),
        .pair_vld_o(vld_b), .pair_rdy_i(rdy_b), .cmpl_i(cmpl_b),
        .sweep_o(sweep_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
        .state_o(state_b)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [SBW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pair list: every (p,q) with q>p in row order, per sweep;
    // the last entry of each sweep carries the last flag.
    task automatic build_model();
        exp_q.delete();
        for (int s = 0; s < SA; s++) begin
            int k;
            k = 0;
            for (int p = 0; p < NA; p++) begin
                for (int q = p + 1; q < NA; q++) begin
                    exp_q.push_back({s[1:0], p[1:0], q[1:0], (k == MA - 1)});
                    k++;
                end
            end
        end
    endtask

    // ---------------- monitors ----------------
    int   done_cnt_a = 0;
    logic mon_en = 1'b0;
    logic prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [1:0] prev_p = '0, prev_q = '0;

    // A valid pair without a transfer must still be offered, unchanged.
    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (mon_en && prev_vld && !prev_rdy) begin
            chk("mon_vld_hold", vld_a, 1);
            chk("mon_pq_hold", {p_a, q_a}, {prev_p, prev_q});
        end
        prev_vld = vld_a;
        prev_rdy = rdy_a;
        prev_p   = p_a;
        prev_q   = q_a;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld_a();
        for (int k = 0; k < 20 && !vld_a; k++) tick();
        chk("wait_vld_a", vld_a, 1);
    endtask

    // Full schedule on DUT A; rnd selects random backpressure and latency.
    task automatic run_a(input bit rnd);
        int hold, d, d0;
        logic [1:0] cp, cq;
        d0 = done_cnt_a;
        build_model();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_busy", busy_a, 1);
        chk("start_vld", vld_a, 1);
        for (int i = 0; i < SA * MA; i++) begin
            wait_vld_a();
            cp = p_a;
            cq = q_a;
            if (rnd) hold = $urandom_range(0, 3);
            else hold = (cp == 2'd1 && cq == 2'd2) ? 5 : 0;
            rdy_a = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("bp_vld", vld_a, 1);
                chk("bp_pq", {p_a, q_a}, {cp, cq});
            end
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else chk("sb_pair", {sweep_a, p_a, q_a, last_a}, exp_q.pop_front());
            rdy_a = 1'b1;
            tick();
            rdy_a = 1'b0;
            chk("hs_vld_drop", vld_a, 0);
            d = rnd ? $urandom_range(1, 4) : 3;
            for (int j = 0; j < d - 1; j++) begin
                start_a = (j == 0);
                tick();
                chk("wait_busy", busy_a, 1);
            end
            start_a = 1'b0;
            cmpl_a  = 1'b1;
            tick();
            cmpl_a  = 1'b0;
            if (i == SA * MA - 1) begin
                chk("done_pulse", done_a, 1);
                chk("done_busy", busy_a, 1);
                chk("done_vld", vld_a, 0);
                chk("done_sweep", sweep_a, SA - 1);
                start_a = 1'b1;
                tick();
                start_a = 1'b0;
                chk("done_clear", done_a, 0);
                chk("idle_busy", busy_a, 0);
                tick();
                chk("start_on_done_ignored", vld_a, 0);
                chk("idle_busy2", busy_a, 0);
            end else begin
                chk("next_offered", vld_a, 1);
                chk("no_early_done", done_a, 0);
            end
        end
        chk("sb_left", exp_q.size(), 0);
        chk("done_count", done_cnt_a - d0, 1);
        chk("err_clean", err_a, 0);
    endtask

    // ---------------- protocol vector table ----------------
    typedef struct {
        logic       start, rdy, cmpl;
        logic       vld, busy, err;
        logic [1:0] p, q;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic s, r, c, v, b, e, input logic [1:0] p, q);
        vec_t t;
        t.start = s; t.rdy = r; t.cmpl = c;
        t.vld = v; t.busy = b; t.err = e; t.p = p; t.q = q;
        return t;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        //             st rdy cm  vld bsy err p  q
        vecs[0]  = mk(0, 0, 1,  0, 0, 1, 0, 1);  // cmpl in IDLE
        vecs[1]  = mk(0, 0, 0,  0, 0, 1, 0, 1);  // err sticky
        vecs[2]  = mk(1, 0, 0,  1, 1, 0, 0, 1);  // start clears err
        vecs[3]  = mk(0, 0, 1,  1, 1, 1, 0, 1);  // cmpl in ISSUE
        vecs[4]  = mk(0, 0, 0,  1, 1, 1, 0, 1);
        vecs[5]  = mk(0, 1, 0,  0, 1, 1, 0, 1);  // transfer
        vecs[6]  = mk(0, 1, 0,  0, 1, 1, 0, 1);  // rdy without vld
        vecs[7]  = mk(0, 0, 1,  1, 1, 1, 0, 2);
        vecs[8]  = mk(1, 1, 0,  0, 1, 1, 0, 2);  // start in ISSUE ignored
        vecs[9]  = mk(1, 0, 0,  0, 1, 1, 0, 2);  // start in WAIT ignored
        vecs[10] = mk(0, 0, 1,  1, 1, 1, 0, 3);
        vecs[11] = mk(0, 1, 0,  0, 1, 1, 0, 3);  // now WAIT on (0,3)

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_vld", vld_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_pq", {p_a, q_a}, 4'b0001);
        chk("rst_last", last_a, 0);
        chk("rst_sweep", sweep_a, 0);
        chk("rst_state", state_a, IDLE);
        chk("rst_last_n2", last_b, 1);

        mon_en = 1'b1;
        foreach (vecs[i]) begin
            start_a = vecs[i].start;
            rdy_a   = vecs[i].rdy;
            cmpl_a  = vecs[i].cmpl;
            tick();
            chk($sformatf("vec%0d_vld", i), vld_a, vecs[i].vld);
            chk($sformatf("vec%0d_busy", i), busy_a, vecs[i].busy);
            chk($sformatf("vec%0d_err", i), err_a, vecs[i].err);
            chk($sformatf("vec%0d_pq", i), {p_a, q_a}, {vecs[i].p, vecs[i].q});
        end
        start_a = 1'b0;
        rdy_a   = 1'b0;
        cmpl_a  = 1'b0;

        // Reset while waiting on (0,3): outputs return to reset values at once.
        mon_en = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_vld", vld_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_pq", {p_a, q_a}, 4'b0001);
        chk("midrst_sweep", sweep_a, 0);
        chk("midrst_err", err_a, 0);
        tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        run_a(1'b0);
        for (int r = 0; r < 3; r++) run_a(1'b1);

        // N=2, one sweep: a single pair that is also the last.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("n2_vld", vld_b, 1);
        chk("n2_pq", {p_b, q_b}, 2'b01);
        chk("n2_last", last_b, 1);
        chk("n2_sweep", sweep_b, 0);
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;
        chk("n2_hs", vld_b, 0);
        cmpl_b = 1'b1;
        tick();
        cmpl_b = 1'b0;
        chk("n2_done", done_b, 1);
        chk("n2_done_busy", busy_b, 1);
        tick();
        chk("n2_done_clear", done_b, 0);
        chk("n2_idle", busy_b, 0);
        chk("n2_err", err_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
